// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned MUL/MULH/DIV/REM unit writing back to the register file.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIVU/REMU write 0 after one cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] dst,
    output logic                  busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            op_q;
    logic [W-1:0]          b_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [CW-1:0]         cnt;
    logic [2*W-1:0]        acc;
    logic [2*W-1:0]        acc_nxt;
    logic [W:0]            mul_sum;
    logic [W-1:0]          res;
    logic                  accept;
    logic                  last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (cnt == LAST);

    // acc holds {high, low}: product halves for multiply, {remainder, quotient} for divide
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);

`ifdef MULDIV_DIV_EN
    logic [W:0] div_diff;
    assign div_diff = acc[2*W-1:W-1] - {1'b0, b_q};
`endif

    always_comb begin
        acc_nxt = {mul_sum, acc[W-1:1]};
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
            if (div_diff[W])
                acc_nxt = {acc[2*W-2:0], 1'b0};
            else
                acc_nxt = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        res = op_q[0] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
`ifndef MULDIV_DIV_EN
        if (op_q[1])
            res = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
`ifndef MULDIV_DIV_EN
                    if (op[1])
                        state_nxt = WB;
`endif
                end
            end
            BUSY: begin
                if (last)
                    state_nxt = WB;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        wen      = (state == WB) && (dst_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            b_q   <= '0;
            dst_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        b_q   <= src_b;
                        dst_q <= dst;
                        cnt   <= '0;
                        acc   <= {{W{1'b0}}, src_a};
`ifndef MULDIV_DIV_EN
                        if (op[1]) begin
                            waddr <= dst;
                            wdata <= '0;
                        end
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        waddr <= dst_q;
                        wdata <= res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Divide expectations follow MULDIV_DIV_EN as seen by this file.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  dst;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] MULU  = 2'b00;
    localparam logic [1:0] MULHU = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] REMU  = 2'b11;

    muldiv_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .dst     (dst),
        .busy    (busy),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, then observe a fixed window of cycles (k = cycles after accept)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input int win, output int lat, output int pulses,
                          output int busy_n, output int rdy_at,
                          output logic [31:0] data, output logic [4:0] addr);
        lat    = -1;
        pulses = 0;
        busy_n = 0;
        rdy_at = -1;
        data   = '0;
        addr   = '0;
        @(negedge clk);
        op       = o;
        src_a    = a;
        src_b    = b;
        dst      = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a    = 32'hDEADBEEF;
        src_b    = 32'h0BADF00D;
        dst      = 5'd31;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (wen) begin
                pulses++;
                if (lat < 0) begin
                    lat  = k;
                    data = wdata;
                    addr = waddr;
                end
            end
            if (busy)
                busy_n++;
            if (in_ready && rdy_at < 0)
                rdy_at = k;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = MULU;
        src_a    = '0;
        src_b    = '0;
        dst      = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if (busy !== 1'b0 || wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_wen: got busy=%b wen=%b want 0 0", busy, wen);
        end
        n_checks++;
        if (waddr !== 5'd0 || wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wport: got %0h/%0h want 0/0", waddr, wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mulu;
        int lat, pulses, busy_n, rdy_at;
        logic [31:0] data;
        logic [4:0]  addr;
        run_op(MULU, 32'd7, 32'd6, 5'd3, 40, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL mulu_latency: got %0d want 33", lat);
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL mulu_pulses: got %0d want 1", pulses);
        end
        n_checks++;
        if (busy_n !== 33) begin
            n_fail++;
            $display("FAIL mulu_busy_cycles: got %0d want 33", busy_n);
        end
        n_checks++;
        if (addr !== 5'd3 || data !== 32'd42) begin
            n_fail++;
            $display("FAIL mulu_7x6: got %0d/%0d want 3/42", addr, data);
        end
        n_checks++;
        if (rdy_at !== 34) begin
            n_fail++;
            $display("FAIL mulu_ready_return: got %0d want 34", rdy_at);
        end
        n_checks++;
        if (waddr !== 5'd3 || wdata !== 32'd42 || wen !== 1'b0) begin
            n_fail++;
            $display("FAIL mulu_hold: got %0d/%0d wen=%b want 3/42 wen=0", waddr, wdata, wen);
        end
    endtask

    task automatic test_mul_patterns;
        int lat, pulses, busy_n, rdy_at;
        logic [31:0] data;
        logic [4:0]  addr;
        run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'hFFFFFFFE || addr !== 5'd7) begin
            n_fail++;
            $display("FAIL mulhu_max: got %0h/%0h want 7/fffffffe", addr, data);
        end
        run_op(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'h00000001) begin
            n_fail++;
            $display("FAIL mulu_max: got %0h want 1", data);
        end
        run_op(MULU, 32'h0000FFFF, 32'h00010001, 5'd9, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL mulu_ffff_x_10001: got %0h want ffffffff", data);
        end
        run_op(MULHU, 32'h80000000, 32'd4, 5'd10, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'd2) begin
            n_fail++;
            $display("FAIL mulhu_2pow33: got %0h want 2", data);
        end
    endtask

    task automatic test_div;
        int lat, pulses, busy_n, rdy_at;
        logic [31:0] data;
        logic [4:0]  addr;
`ifdef MULDIV_DIV_EN
        run_op(DIVU, 32'd100, 32'd7, 5'd11, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'd14 || lat !== 33 || pulses !== 1) begin
            n_fail++;
            $display("FAIL divu_100_7: got %0d lat=%0d n=%0d want 14 lat=33 n=1", data, lat, pulses);
        end
        run_op(REMU, 32'd100, 32'd7, 5'd12, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'd2 || addr !== 5'd12) begin
            n_fail++;
            $display("FAIL remu_100_7: got %0d/%0d want 12/2", addr, data);
        end
        run_op(DIVU, 32'd9, 32'd0, 5'd13, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'hFFFFFFFF || lat !== 33) begin
            n_fail++;
            $display("FAIL divu_by_zero: got %0h lat=%0d want ffffffff lat=33", data, lat);
        end
        run_op(REMU, 32'd5, 32'd0, 5'd14, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'd5) begin
            n_fail++;
            $display("FAIL remu_by_zero: got %0h want 5", data);
        end
        run_op(DIVU, 32'hFFFFFFFF, 32'd1, 5'd15, 36, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (data !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divu_max_by_1: got %0h want ffffffff", data);
        end
`else
        run_op(DIVU, 32'd100, 32'd7, 5'd11, 8, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (lat !== 1 || pulses !== 1) begin
            n_fail++;
            $display("FAIL nodiv_latency: got lat=%0d n=%0d want lat=1 n=1", lat, pulses);
        end
        n_checks++;
        if (data !== 32'd0 || addr !== 5'd11) begin
            n_fail++;
            $display("FAIL nodiv_data: got %0d/%0h want 11/0", addr, data);
        end
        n_checks++;
        if (rdy_at !== 2 || busy_n !== 1) begin
            n_fail++;
            $display("FAIL nodiv_timing: got rdy=%0d busy=%0d want 2 1", rdy_at, busy_n);
        end
        run_op(REMU, 32'd100, 32'd0, 5'd0, 8, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (pulses !== 0 || rdy_at !== 2) begin
            n_fail++;
            $display("FAIL nodiv_dst0: got n=%0d rdy=%0d want 0 2", pulses, rdy_at);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        int rdy_n  = 0;
        @(negedge clk);
        op       = MULU;
        src_a    = 32'd7;
        src_b    = 32'd6;
        dst      = 5'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || wen !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b wen=%b rdy=%b want 0 0 1", busy, wen, in_ready);
        end
        n_checks++;
        if (wdata !== 32'd0 || waddr !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_wport: got %0h/%0h want 0/0", waddr, wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wen)
                pulses++;
            if (in_ready)
                rdy_n++;
        end
        n_checks++;
        if (pulses !== 0 || rdy_n !== 40) begin
            n_fail++;
            $display("FAIL rstmid_after: got n=%0d rdy=%0d want 0 40", pulses, rdy_n);
        end
    endtask

    task automatic test_back_to_back;
        int lat1 = -1;
        int lat2 = -1;
        int pulses = 0;
        int acc_k = -1;
        logic [31:0] d1 = '0;
        logic [31:0] d2 = '0;
        logic [4:0]  a1 = '0;
        logic [4:0]  a2 = '0;
        logic        rdy5 = 1'b1;
        @(negedge clk);
        op       = MULU;
        src_a    = 32'd7;
        src_b    = 32'd6;
        dst      = 5'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        src_a = 32'd9;
        src_b = 32'd9;
        dst   = 5'd4;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 5)
                rdy5 = in_ready;
            if (wen) begin
                pulses++;
                if (lat1 < 0) begin
                    lat1 = k;
                    d1   = wdata;
                    a1   = waddr;
                end else if (lat2 < 0) begin
                    lat2 = k;
                    d2   = wdata;
                    a2   = waddr;
                end
            end
            if (in_ready && in_valid && acc_k < 0) begin
                acc_k = k;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (rdy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_busy: got %b want 0", rdy5);
        end
        n_checks++;
        if (lat1 !== 33 || d1 !== 32'd42 || a1 !== 5'd3) begin
            n_fail++;
            $display("FAIL b2b_first: got k=%0d %0d/%0d want k=33 3/42", lat1, a1, d1);
        end
        n_checks++;
        if (acc_k !== 34) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got %0d want 34", acc_k);
        end
        n_checks++;
        if (lat2 !== 67 || d2 !== 32'd81 || a2 !== 5'd4 || pulses !== 2) begin
            n_fail++;
            $display("FAIL b2b_second: got k=%0d %0d/%0d n=%0d want k=67 4/81 n=2", lat2, a2, d2, pulses);
        end
    endtask

    task automatic test_dst_zero;
        int lat, pulses, busy_n, rdy_at;
        logic [31:0] data;
        logic [4:0]  addr;
        run_op(MULU, 32'd3, 32'd4, 5'd0, 40, lat, pulses, busy_n, rdy_at, data, addr);
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL dst0_no_wen: got %0d pulses want 0", pulses);
        end
        n_checks++;
        if (busy_n !== 33 || rdy_at !== 34) begin
            n_fail++;
            $display("FAIL dst0_timing: got busy=%0d rdy=%0d want 33 34", busy_n, rdy_at);
        end
    endtask

    initial begin
        test_reset;
        test_mulu;
        test_mul_patterns;
        test_div;
        test_reset_mid;
        test_back_to_back;
        test_dst_zero;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
